hw_jpegenc_core: RTL and testbench

Front end of the hardware JPEG encoder. Accepts one RGB pixel per clock, converts it to 8-bit YCbCr with JFIF integer arithmetic, and collects the luma samples of one 8x8 block in raster order. On request it presents the whole block as a 64-sample parallel bus for the downstream DCT stage. Per-pixel Cb/Cr results are also output for the chroma paths.

---
 rtl/hw_jpegenc_core.sv | 117 +++++++++++
 tb/tb_hw_jpegenc_core.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/hw_jpegenc_core.sv
// JPEG encoder front end: RGB -> YCbCr (JFIF integer) and an 8x8 luma
// block buffer presented as a 64-sample parallel snapshot bus.
module hw_jpegenc_core (
  input  logic         clock,
  input  logic         reset,
  input  logic [7:0]   red,
  input  logic [7:0]   green,
  input  logic [7:0]   blue,
  input  logic         input_enable,
  input  logic         output_enable,
  output logic [7:0]   y_out,
  output logic [7:0]   cb_out,
  output logic [7:0]   cr_out,
  output logic         ycc_valid,
  output logic         block_ready,
  output logic [511:0] pix_data
);

  function automatic logic [7:0] sat8(
    input logic signed [19:0] v
  );
    if (v < 20'sd0)
      return 8'd0;
    else if (v > 20'sd255)
      return 8'hff;
    else
      return v[7:0];
  endfunction

  logic signed [19:0] r_s, g_s, b_s;
  logic signed [19:0] y_sum, cb_sum, cr_sum;
  logic signed [19:0] y_sh, cb_sh, cr_sh;

  assign r_s = {12'd0, red};
  assign g_s = {12'd0, green};
  assign b_s = {12'd0, blue};

  assign y_sum  = 20'sd77 * r_s + 20'sd150 * g_s
                + 20'sd29 * b_s + 20'sd128;
  assign cb_sum = 20'sd128 * b_s - 20'sd43 * r_s
                - 20'sd85 * g_s + 20'sd128;
  assign cr_sum = 20'sd128 * r_s - 20'sd107 * g_s
                - 20'sd21 * b_s + 20'sd128;

  // floor shift, then chroma offset before clamping
  assign y_sh  = y_sum >>> 8;
  assign cb_sh = (cb_sum >>> 8) + 20'sd128;
  assign cr_sh = (cr_sum >>> 8) + 20'sd128;

  logic [7:0]   y_q, cb_q, cr_q;
  logic         valid_q;
  logic [7:0]   mem_q [64];
  logic [5:0]   wr_ptr_q;
  logic         rdy_q, rdy_d;
  logic [511:0] pix_q;
  logic [511:0] mem_flat;
  logic         wr_last;

  always_comb begin
    mem_flat = '0;
    for (int i = 0; i < 64; i++)
      mem_flat[8*i +: 8] = mem_q[i];
  end

  assign wr_last = valid_q && (wr_ptr_q == 6'd63);

  always_comb begin
    rdy_d = rdy_q;
    if (output_enable)
      rdy_d = 1'b0;
    if (wr_last)
      rdy_d = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      y_q     <= '0;
      cb_q    <= '0;
      cr_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= input_enable;
      if (input_enable) begin
        y_q  <= sat8(y_sh);
        cb_q <= sat8(cb_sh);
        cr_q <= sat8(cr_sh);
      end
    end
  end

  // snapshot reads mem_flat, so it sees pre-write contents
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 64; i++)
        mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rdy_q    <= 1'b0;
      pix_q    <= '0;
    end else begin
      if (valid_q) begin
        mem_q[wr_ptr_q] <= y_q;
        wr_ptr_q        <= wr_ptr_q + 6'd1;
      end
      rdy_q <= rdy_d;
      if (output_enable)
        pix_q <= mem_flat;
    end
  end

  assign y_out       = y_q;
  assign cb_out      = cb_q;
  assign cr_out      = cr_q;
  assign ycc_valid   = valid_q;
  assign block_ready = rdy_q;
  assign pix_data    = pix_q;

endmodule

// File: tb/tb_hw_jpegenc_core.sv
// Randomized bench for hw_jpegenc_core against a pixel-stream
// reference model plus fixed colour-point and block scenarios.
module tb_hw_jpegenc_core;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [7:0]   red = '0, green = '0, blue = '0;
  logic         input_enable = 1'b0;
  logic         output_enable = 1'b0;
  logic [7:0]   y_out, cb_out, cr_out;
  logic         ycc_valid, block_ready;
  logic [511:0] pix_data;

  int checks = 0;
  int failures = 0;

  hw_jpegenc_core dut (
    .clock(clock), .reset(reset),
    .red(red), .green(green), .blue(blue),
    .input_enable(input_enable),
    .output_enable(output_enable),
    .y_out(y_out), .cb_out(cb_out), .cr_out(cr_out),
    .ycc_valid(ycc_valid), .block_ready(block_ready),
    .pix_data(pix_data)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag,
                       input logic [511:0] got,
                       input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference: floor(v/256) and clamp to a byte
  function automatic int fdiv256(input int v);
    if (v >= 0) return v / 256;
    return -((-v + 255) / 256);
  endfunction

  function automatic int sat(input int v);
    if (v < 0) return 0;
    if (v > 255) return 255;
    return v;
  endfunction

  function automatic int ref_y(input int r, g, b);
    return sat(fdiv256(77*r + 150*g + 29*b + 128));
  endfunction
  function automatic int ref_cb(input int r, g, b);
    return sat(fdiv256(-43*r - 85*g + 128*b + 128) + 128);
  endfunction
  function automatic int ref_cr(input int r, g, b);
    return sat(fdiv256(128*r - 107*g - 21*b + 128) + 128);
  endfunction

  // model: last converted pixel, luma stream count, buffer, snapshot
  int m_y, m_cb, m_cr;
  bit m_v, m_rdy;
  int m_cnt;
  int m_buf [64];
  int m_pix [64];

  task automatic model_reset();
    m_y = 0; m_cb = 0; m_cr = 0;
    m_v = 0; m_rdy = 0; m_cnt = 0;
    for (int i = 0; i < 64; i++) begin
      m_buf[i] = 0;
      m_pix[i] = 0;
    end
  endtask

  function automatic logic [511:0] model_pix();
    logic [511:0] e;
    e = '0;
    for (int i = 0; i < 64; i++)
      e[8*i +: 8] = m_pix[i][7:0];
    return e;
  endfunction

  task automatic compare_all(input string tag);
    check({tag, ".valid"}, 512'(ycc_valid), 512'(m_v));
    check({tag, ".y"},     512'(y_out),  512'(m_y[7:0]));
    check({tag, ".cb"},    512'(cb_out), 512'(m_cb[7:0]));
    check({tag, ".cr"},    512'(cr_out), 512'(m_cr[7:0]));
    check({tag, ".rdy"},   512'(block_ready), 512'(m_rdy));
    check({tag, ".pix"},   pix_data, model_pix());
  endtask

  // one clock: drive at negedge, model the edge, check 1 ns after it
  task automatic step(input int r, g, b,
                      input bit ie, oe);
    red = r[7:0]; green = g[7:0]; blue = b[7:0];
    input_enable = ie;
    output_enable = oe;
    @(posedge clock);
    if (oe)
      for (int i = 0; i < 64; i++) m_pix[i] = m_buf[i];
    if (m_v) begin
      m_buf[m_cnt % 64] = m_y;
      if (m_cnt % 64 == 63) m_rdy = 1;
      else if (oe) m_rdy = 0;
      m_cnt++;
    end else if (oe) begin
      m_rdy = 0;
    end
    if (ie) begin
      m_y = ref_y(r, g, b);
      m_cb = ref_cb(r, g, b);
      m_cr = ref_cr(r, g, b);
    end
    m_v = ie;
    #1;
    compare_all("step");
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    @(negedge clock);
    reset = 1'b0;
  endtask

  function automatic logic [511:0] grey_block();
    logic [511:0] e;
    for (int i = 0; i < 64; i++) e[8*i +: 8] = 8'(i);
    return e;
  endfunction

  initial begin
    model_reset();
    @(negedge clock);
    #1;
    compare_all("por");
    @(negedge clock);
    reset = 1'b0;

    // colour points
    step(255, 255, 255, 1, 0);
    check("white.y", 512'(y_out), 512'(255));
    check("white.cb", 512'(cb_out), 512'(128));
    check("white.cr", 512'(cr_out), 512'(128));
    check("white.v", 512'(ycc_valid), 512'(1));
    step(0, 0, 0, 0, 0);
    check("idle.v", 512'(ycc_valid), 512'(0));
    step(0, 0, 0, 1, 0);
    check("black.y", 512'(y_out), 512'(0));
    check("black.cb", 512'(cb_out), 512'(128));
    check("black.cr", 512'(cr_out), 512'(128));
    step(255, 0, 0, 1, 0);
    check("red.y", 512'(y_out), 512'(77));
    check("red.cb", 512'(cb_out), 512'(85));
    check("red.cr", 512'(cr_out), 512'(255));
    step(0, 0, 255, 1, 0);
    check("blue.y", 512'(y_out), 512'(29));
    check("blue.cb", 512'(cb_out), 512'(255));
    check("blue.cr", 512'(cr_out), 512'(107));
    step(0, 0, 0, 0, 0);
    check("idle2.v", 512'(ycc_valid), 512'(0));

    // asynchronous reset mid-stream
    for (int i = 0; i < 5; i++)
      step($urandom_range(255), $urandom_range(255),
           $urandom_range(255), 1, 0);
    step(0, 0, 0, 0, 1);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    compare_all("areset");
    @(negedge clock);
    reset = 1'b0;
    step(10, 200, 30, 1, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    check("rst.s0", 512'(pix_data[7:0]),
          512'(ref_y(10, 200, 30)));
    check("rst.rest", 512'(pix_data[511:8]), 512'(0));

    // full grey block back to back
    do_reset();
    for (int i = 0; i < 64; i++) step(i, i, i, 1, 0);
    check("blk.rdy_pre", 512'(block_ready), 512'(0));
    step(0, 0, 0, 0, 0);
    check("blk.rdy", 512'(block_ready), 512'(1));
    step(0, 0, 0, 0, 1);
    check("blk.pix", pix_data, grey_block());
    check("blk.rdy_clr", 512'(block_ready), 512'(0));

    // collision: snapshot on the edge writing entry 63
    for (int i = 0; i < 64; i++) step(200, 200, 200, 1, 0);
    step(0, 0, 0, 0, 1);
    check("col.old63", 512'(pix_data[511:504]), 512'(63));
    check("col.rdy", 512'(block_ready), 512'(1));
    step(0, 0, 0, 0, 1);
    check("col.new63", 512'(pix_data[511:504]), 512'(200));
    check("col.rdy_clr", 512'(block_ready), 512'(0));

    // same block with gaps
    do_reset();
    for (int i = 0; i < 64; i++) begin
      step(i, i, i, 1, 0);
      step(0, 0, 0, 0, 0);
    end
    check("gap.rdy", 512'(block_ready), 512'(1));
    step(0, 0, 0, 0, 1);
    check("gap.pix", pix_data, grey_block());
    check("gap.rdy_clr", 512'(block_ready), 512'(0));

    // wrap: 70 random pixels
    do_reset();
    for (int i = 0; i < 70; i++)
      step($urandom_range(255), $urandom_range(255),
           $urandom_range(255), 1, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);

    // random traffic
    for (int n = 0; n < 600; n++)
      step($urandom_range(255), $urandom_range(255),
           $urandom_range(255),
           ($urandom_range(3) != 0),
           ($urandom_range(9) == 0));

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
